// File: rtl/regfile_dump_unit_if.sv
// Bundle between the register-file dump unit and its environment: control,
// read-port and streamed-output signals.
interface regfile_dump_unit_if;
    logic        start;
    logic        abort;
    logic [4:0]  rsel;
    logic [31:0] rdat;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    modport master (
        input  start, abort, rdat, out_ready,
        output rsel, out_valid, out_idx, out_data, busy, done
    );

    modport slave (
        output start, abort, rdat, out_ready,
        input  rsel, out_valid, out_idx, out_data, busy, done
    );
endinterface

// File: rtl/regfile_dump_unit.sv
// Debug reader that walks a register index range, reads each word through the
// register-file read port and streams (index, value) on a valid/ready output.
module regfile_dump_unit #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input logic                 CLK,
    input logic                 nRST,
    regfile_dump_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, PRESENT, FINISH} state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t      state, next_state;
    logic [4:0]  cnt, next_cnt;
    logic [4:0]  idx_q;
    logic [31:0] data_q;
    logic        capture;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            cnt    <= FIRST_IDX;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (capture) begin
                data_q <= bus.rdat;
                idx_q  <= cnt;
            end
        end
    end

    // Termination is checked before the increment, so the counter never wraps.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    next_state = READ;
                    next_cnt   = FIRST_IDX;
                end
            end
            READ: begin
                capture = 1'b1;
                if (SKIP_ZERO && (bus.rdat == '0)) begin
                    if (cnt == LAST_IDX) next_state = FINISH;
                    else                 next_cnt   = cnt + 5'd1;
                end else begin
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (cnt == LAST_IDX) begin
                        next_state = FINISH;
                    end else begin
                        next_state = READ;
                        next_cnt   = cnt + 5'd1;
                    end
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
        endcase
        if (bus.abort && (state != IDLE)) begin
            next_state = IDLE;
            next_cnt   = FIRST_IDX;
            capture    = 1'b0;
        end
    end

    assign bus.rsel      = (state == IDLE) ? '0 : cnt;
    assign bus.out_valid = (state == PRESENT);
    assign bus.out_idx   = idx_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Scoreboard bench: one default dump unit and one with SKIP_ZERO=1, each with
// its own register-file model, stimulus pushing expected words into queues.
module tb_regfile_dump_unit;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    regfile_dump_unit_if ifa ();
    regfile_dump_unit_if ifb ();

    logic [31:0] rega [32];
    logic [31:0] regb [32];
    assign ifa.rdat = rega[ifa.rsel];
    assign ifb.rdat = regb[ifb.rsel];

    regfile_dump_unit dut_a (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (ifa)
    );

    regfile_dump_unit #(
        .FIRST_REG (0),
        .LAST_REG  (31),
        .SKIP_ZERO (1'b1)
    ) dut_b (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (ifb)
    );

    word_t qa[$];
    word_t qb[$];
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int done_a = 0;
    int done_b = 0;
    int valid_b = 0;
    int hs31_cyc = -1;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: wait expired, required event not seen", name);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Monitor A: every accepted word is matched against the queue head.
    always @(negedge CLK) begin
        word_t w;
        if (nRST && ifa.out_valid && ifa.out_ready && !ifa.abort) begin
            if (qa.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL a_unexpected: got idx %0d data 0x%08h, expected no word", ifa.out_idx, ifa.out_data);
            end else begin
                w = qa.pop_front();
                chk("a_idx", 32'(ifa.out_idx), 32'(w.idx));
                chk("a_data", ifa.out_data, w.data);
            end
            if (ifa.out_idx == 5'd31) hs31_cyc = cyc;
        end
        if (ifa.done) done_a++;
    end

    always @(negedge CLK) begin
        word_t w;
        if (ifb.out_valid) valid_b++;
        if (nRST && ifb.out_valid && ifb.out_ready && !ifb.abort) begin
            if (qb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL b_unexpected: got idx %0d data 0x%08h, expected no word", ifb.out_idx, ifb.out_data);
            end else begin
                w = qb.pop_front();
                chk("b_idx", 32'(ifb.out_idx), 32'(w.idx));
                chk("b_data", ifb.out_data, w.data);
            end
        end
        if (ifb.done) done_b++;
    end

    function automatic logic [31:0] preload(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    endfunction

    task automatic push_a(input int lo, input int hi);
        word_t w;
        for (int i = lo; i <= hi; i++) begin
            w.idx  = 5'(i);
            w.data = preload(i);
            qa.push_back(w);
        end
    endtask

    task automatic pulse_start_a;
        ifa.start = 1'b1;
        tick;
        ifa.start = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!ifa.done && n < 300) begin
            tick;
            n++;
        end
        if (!ifa.done) timeout(name);
    endtask

    task automatic wait_idx_a(input logic [4:0] idx, input string name);
        int n = 0;
        while (!(ifa.out_valid && ifa.out_idx == idx) && n < 100) begin
            tick;
            n++;
        end
        if (!(ifa.out_valid && ifa.out_idx == idx)) timeout(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w;
        int lat;
        int n;
        int vb0;

        nRST = 1'b0;
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.out_ready = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rega[i] = preload(i);
            regb[i] = 32'h0;
        end
        #12;
        chk("rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_rsel", 32'(ifa.rsel), 32'd0);
        chk("rst_idx", 32'(ifa.out_idx), 32'd0);
        chk("rst_data", ifa.out_data, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        tick;

        // Full dump, ready held high
        push_a(0, 31);
        ifa.out_ready = 1'b1;
        pulse_start_a;
        lat = 1;
        while (!ifa.out_valid && lat < 10) begin
            tick;
            lat++;
        end
        chk("t1_latency", 32'(lat), 32'd2);
        wait_done_a("t1_done");
        chk("t1_done_timing", 32'(cyc), 32'(hs31_cyc + 1));
        chk("t1_busy_in_finish", 32'(ifa.busy), 32'd1);
        tick;
        chk("t1_done_pulse", 32'(ifa.done), 32'd0);
        chk("t1_busy_after", 32'(ifa.busy), 32'd0);
        chk("t1_done_count", 32'(done_a), 32'd1);
        chk("t1_queue_empty", 32'(qa.size()), 32'd0);

        // Backpressure at index 3
        push_a(0, 31);
        pulse_start_a;
        wait_idx_a(5'd3, "t2_reach_idx3");
        ifa.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("t2_valid_held", 32'(ifa.out_valid), 32'd1);
            chk("t2_data_held", ifa.out_data, 32'h1000_0003);
            chk("t2_rsel_held", 32'(ifa.rsel), 32'd3);
        end
        ifa.out_ready = 1'b1;
        wait_done_a("t2_done");
        tick;
        chk("t2_done_count", 32'(done_a), 32'd2);
        chk("t2_queue_empty", 32'(qa.size()), 32'd0);

        // Abort while presenting index 10; the word in flight is dropped
        push_a(0, 9);
        pulse_start_a;
        wait_idx_a(5'd10, "t5_reach_idx10");
        ifa.abort = 1'b1;
        tick;
        ifa.abort = 1'b0;
        chk("t5_valid", 32'(ifa.out_valid), 32'd0);
        chk("t5_busy", 32'(ifa.busy), 32'd0);
        chk("t5_done", 32'(ifa.done), 32'd0);
        chk("t5_rsel", 32'(ifa.rsel), 32'd0);
        tick;
        tick;
        chk("t5_no_done", 32'(done_a), 32'd2);
        chk("t5_queue_empty", 32'(qa.size()), 32'd0);
        push_a(0, 31);
        pulse_start_a;
        wait_done_a("t5_restart_done");
        tick;
        chk("t5_restart_done_count", 32'(done_a), 32'd3);
        chk("t5_restart_queue", 32'(qa.size()), 32'd0);

        // Reset mid-dump, with start held high while busy
        push_a(0, 6);
        pulse_start_a;
        tick;
        ifa.start = 1'b1;
        wait_idx_a(5'd7, "t6_reach_idx7");
        nRST = 1'b0;
        #1;
        chk("t6_valid", 32'(ifa.out_valid), 32'd0);
        chk("t6_busy", 32'(ifa.busy), 32'd0);
        chk("t6_done", 32'(ifa.done), 32'd0);
        chk("t6_rsel", 32'(ifa.rsel), 32'd0);
        chk("t6_idx", 32'(ifa.out_idx), 32'd0);
        chk("t6_data", ifa.out_data, 32'd0);
        ifa.start = 1'b0;
        tick;
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("t6_idle_busy", 32'(ifa.busy), 32'd0);
            chk("t6_idle_valid", 32'(ifa.out_valid), 32'd0);
        end
        chk("t6_queue_empty", 32'(qa.size()), 32'd0);
        chk("t6_done_count", 32'(done_a), 32'd3);

        // SKIP_ZERO: only r5 and r31 nonzero
        regb[5]  = 32'hDEAD_BEEF;
        regb[31] = 32'h0000_0001;
        w.idx = 5'd5;  w.data = 32'hDEAD_BEEF; qb.push_back(w);
        w.idx = 5'd31; w.data = 32'h0000_0001; qb.push_back(w);
        ifb.out_ready = 1'b1;
        ifb.start = 1'b1;
        tick;
        ifb.start = 1'b0;
        n = 0;
        while (!ifb.done && n < 200) begin
            tick;
            n++;
        end
        if (!ifb.done) timeout("t3_done");
        tick;
        chk("t3_done_count", 32'(done_b), 32'd1);
        chk("t3_queue_empty", 32'(qb.size()), 32'd0);

        // SKIP_ZERO, all zero: no words, done after 32 READ cycles
        regb[5]  = 32'h0;
        regb[31] = 32'h0;
        vb0 = valid_b;
        ifb.start = 1'b1;
        tick;
        ifb.start = 1'b0;
        n = 1;
        while (!ifb.done && n < 100) begin
            tick;
            n++;
        end
        chk("t4_done_cycles", 32'(n), 32'd33);
        tick;
        chk("t4_no_valid", 32'(valid_b), 32'(vb0));
        chk("t4_done_count", 32'(done_b), 32'd2);
        chk("t4_busy_after", 32'(ifb.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
